// File: rtl/svc_rv_io_uart_pkg.sv
// Register map, STATUS bit layout and FSM state encoding for the memory-mapped UART transmitter.
// Shared with the firmware header generator, so keep offsets and bit positions stable.
package svc_rv_io_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_BUSY_BIT     = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A divisor of zero is treated as one clock per bit.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/svc_rv_io_uart_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit so full and empty differ on wrap.
module svc_rv_io_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count    = wptr - rptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/svc_rv_io_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIV registers, byte FIFO and 8N1 serialiser.
module svc_rv_io_uart_tx
  import svc_rv_io_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_t   state;
  logic [15:0] div;
  logic [15:0] period;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        overflow;
  logic        busy;
  logic        full;
  logic        empty;
  logic [AW:0] fifo_count;
  logic [7:0]  pop_data;
  logic        txdata_wr;
  logic        push;
  logic        pop;
  logic        baud_end;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign busy      = (state != ST_IDLE);
  assign txdata_wr = !rst && io_wen && (io_waddr[3:2] == REG_TXDATA) && io_wstrb[0];
  assign push      = txdata_wr && !full;
  assign baud_end  = (baud_cnt == period - 16'd1);
  // Pop exactly when the FSM launches a new start bit.
  assign pop       = !rst && !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_end));
  assign unused_ok = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                       io_wdata[31:16], io_wstrb[3:2], fifo_count};

  svc_rv_io_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (io_wdata[7:0]),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (io_raddr[3:2])
      REG_STATUS: begin
        rd_val[STATUS_FULL_BIT]     = full;
        rd_val[STATUS_EMPTY_BIT]    = empty;
        rd_val[STATUS_BUSY_BIT]     = busy;
        rd_val[STATUS_OVERFLOW_BIT] = overflow;
      end
      REG_DIV: rd_val = {16'b0, div};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DIV_RESET;
      overflow <= 1'b0;
      io_rdata <= '0;
    end else begin
      if (io_wen && io_waddr[3:2] == REG_DIV) begin
        if (io_wstrb[0]) div[7:0]  <= io_wdata[7:0];
        if (io_wstrb[1]) div[15:8] <= io_wdata[15:8];
      end
      if (txdata_wr && full) begin
        overflow <= 1'b1;
      end else if (io_wen && io_waddr[3:2] == REG_STATUS && io_wstrb[0]
                   && io_wdata[STATUS_OVERFLOW_BIT]) begin
        overflow <= 1'b0;
      end
      if (io_ren) io_rdata <= rd_val;
    end
  end

  // uart_tx is updated on the same edge as the state, so it always reflects the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      uart_tx  <= 1'b1;
      period   <= 16'd1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty) begin
            state    <= ST_START;
            uart_tx  <= 1'b0;
            shreg    <= pop_data;
            period   <= bit_period(div);
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state    <= ST_DATA;
            uart_tx  <= shreg[0];
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= ST_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (!empty) begin
              state   <= ST_START;
              uart_tx <= 1'b0;
              shreg   <= pop_data;
              period  <= bit_period(div);
            end else begin
              state   <= ST_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// Scoreboard bench for svc_rv_io_uart_tx: register reads and serial frames are checked by monitors.
module tb_svc_rv_io_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        uart_tx;

  svc_rv_io_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_ren   (io_ren),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .uart_tx  (uart_tx)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int   cyc = 0;
  logic ren_d = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ren_d <= io_ren && !rst;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Read expectations: 32-bit data. Frame expectations: {start_cycle[31:0], period[15:0], frame[9:0]}.
  logic [31:0] exp_q[$];
  logic [57:0] tx_exp_q[$];
  logic [15:0] tx_period = 16'd434;
  int          line_free = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Driver tasks: entered and left at posedge+1.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    io_wen = 1'b1; io_waddr = addr; io_wdata = data; io_wstrb = strb;
    @(posedge clk); #1;
    io_wen = 1'b0; io_wstrb = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] want);
    exp_q.push_back(want);
    io_ren = 1'b1; io_raddr = addr;
    @(posedge clk); #1;
    io_ren = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    int st;
    st = cyc + 2;
    if (st < line_free) st = line_free;
    tx_exp_q.push_back({st[31:0], tx_period, 1'b1, b, 1'b0});
    line_free = st + 10 * int'(tx_period);
    bus_write(32'h0, {24'b0, b}, 4'b0001);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_done(input int budget);
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (tx_exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL tx_timeout: %0d frames outstanding after %0d cycles", tx_exp_q.size(), budget);
      tx_exp_q.delete();
    end
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_rdata", io_rdata, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    tx_exp_q.delete();
    line_free = 0;
    tx_period = 16'd434;
    @(posedge clk); #1;
  endtask

  // Read monitor: one cycle after an accepted read strobe.
  always @(negedge clk) begin
    if (ren_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: rdata 0x%0h with no expectation", io_rdata);
      end else begin
        check("rdata", io_rdata, exp_q.pop_front());
      end
    end
  end

  // Serial monitor: captures each frame bit-by-bit and checks pattern, timing and bit stability.
  initial begin : tx_monitor
    logic [57:0] ent;
    logic [9:0]  got;
    int          p;
    int          start;
    logic        stable;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected_start: uart_tx low at cycle %0d", cyc);
          while (uart_tx !== 1'b1 && !rst) @(negedge clk);
        end else begin
          ent = tx_exp_q[0];
          p = int'(ent[25:10]);
          start = cyc;
          got = '0;
          stable = 1'b1;
          aborted = 1'b0;
          for (int k = 1; k < 10 * p; k++) begin
            @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (k % p == 0) got[k / p] = uart_tx;
            else if (uart_tx !== got[k / p]) stable = 1'b0;
          end
          if (!aborted) begin
            void'(tx_exp_q.pop_front());
            check("tx_frame", {22'b0, got}, {22'b0, ent[9:0]});
            check("tx_start_cycle", start, ent[57:26]);
            check("tx_bit_stable", {31'b0, stable}, 32'h1);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Reset values, decode aliasing, partial DIV write and rdata hold
    bus_read(32'h8, 32'h1B2);
    bus_read(32'h1004, 32'h2);
    bus_read(32'h0, 32'h0);
    bus_read(32'hC, 32'h0);
    bus_write(32'h8, 32'hFFFF_FF07, 4'b0001);
    bus_read(32'hF008, 32'h107);
    idle(3);
    @(negedge clk);
    check("rdata_hold", io_rdata, 32'h107);
    @(posedge clk); #1;

    // DIV=4, 0x55, STATUS read in the write cycle sees the pre-write value
    bus_write(32'h8, 32'h4, 4'b0011);
    tx_period = 16'd4;
    exp_q.push_back(32'h2);
    io_ren = 1'b1; io_raddr = 32'h4;
    tx_write(8'h55);
    io_ren = 1'b0;
    idle(6);
    bus_read(32'h4, 32'h6);      // busy, FIFO already drained
    wait_tx_done(200);
    bus_read(32'h4, 32'h2);

    // DIV=2, three consecutive writes -> contiguous frames
    bus_write(32'h8, 32'h2, 4'b0011);
    tx_period = 16'd2;
    tx_write(8'h01);
    tx_write(8'h02);
    tx_write(8'h03);
    wait_tx_done(300);
    bus_read(32'h4, 32'h2);

    // DIV=0 -> one clock per bit
    bus_write(32'h8, 32'h0, 4'b0011);
    tx_period = 16'd1;
    tx_write(8'hA5);
    tx_write(8'h3C);
    wait_tx_done(100);

    // DIV written mid-frame only affects the following frame
    bus_write(32'h8, 32'h4, 4'b0011);
    tx_period = 16'd4;
    tx_write(8'h0F);
    idle(3);
    bus_write(32'h8, 32'h2, 4'b0011);
    wait_tx_done(200);
    tx_period = 16'd2;
    tx_write(8'hF0);
    wait_tx_done(200);

    // Overflow: first byte in flight, four queued, sixth dropped
    bus_write(32'h8, 32'd100, 4'b0011);
    tx_period = 16'd100;
    tx_write(8'h11);
    bus_write(32'h0, 32'h12, 4'b0001);
    bus_write(32'h0, 32'h13, 4'b0001);
    bus_write(32'h0, 32'h14, 4'b0001);
    bus_write(32'h0, 32'h15, 4'b0001);
    bus_write(32'h0, 32'h16, 4'b0001);
    bus_read(32'h4, 32'hD);      // overflow | busy | full
    bus_write(32'h4, 32'h8, 4'b0001);
    bus_read(32'h4, 32'h5);      // busy | full
    do_reset();
    bus_read(32'h4, 32'h2);

    // Reset during data bit 3 aborts the frame and flushes the queue
    bus_write(32'h8, 32'h4, 4'b0011);
    tx_period = 16'd4;
    tx_write(8'h3C);
    bus_write(32'h0, 32'h77, 4'b0001);
    idle(17);
    do_reset();
    bus_read(32'h4, 32'h2);
    idle(80);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL rd_pending: %0d reads never returned", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
